// File: rtl/execute_muldiv.sv
// execute_muldiv: HI/LO unit for the E stage. Handles MTHI/MTLO in a single
// cycle and runs MULT/MULTU/DIV/DIVU as 32 radix-2 iterations on a 64-bit
// accumulator, followed by one sign-fix cycle that commits HI/LO.
// Signed operations are done on magnitudes, and the signs are fixed up at the end.
//
// Handshake: an op on op_e is taken only in IDLE with sig_clr=0. While busy,
// any E-stage op or MFHI/MFLO raises stall_req so the pipeline holds that
// instruction. It is presented again after busy falls.
module execute_muldiv (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  op_e,
  input  logic [31:0] src_a_e,
  input  logic [31:0] src_b_e,
  input  logic        hilo_read_e,
  input  logic        sig_clr,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        stall_req,
  output logic        done,
  output logic [1:0]  state_dbg
);

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;
  localparam logic [2:0] OP_RSVD  = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] opnd_q, opnd_d;     // multiplicand for MUL, divisor for DIV
  logic        is_div_q, is_div_d;
  logic        neg_lo_q, neg_lo_d;  // negate product / quotient
  logic        neg_hi_q, neg_hi_d;  // negate remainder (dividend sign)
  logic        dz_q, dz_d;          // divide by zero seen at accept
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;

  // Operand magnitudes for the op currently on op_e
  logic        signed_op;
  logic [31:0] mag_a, mag_b;
  logic        b_zero;
  assign signed_op = (op_e == OP_MULT) || (op_e == OP_DIV);
  assign mag_a     = (signed_op && src_a_e[31]) ? (32'd0 - src_a_e) : src_a_e;
  assign mag_b     = (signed_op && src_b_e[31]) ? (32'd0 - src_b_e) : src_b_e;
  assign b_zero    = (src_b_e == 32'd0);

  // One shift-add step: add the multiplicand when the low multiplier bit is set
  logic [32:0] mul_sum;
  assign mul_sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);

  // One restoring step: shifted partial remainder minus the divisor
  logic [33:0] div_trial;
  assign div_trial = {1'b0, acc_q[63:31]} - {2'b00, opnd_q};

  // Sign-corrected results used in FIX
  logic [63:0] prod_fix;
  logic [31:0] quot_fix, rem_fix;
  assign prod_fix = neg_lo_q ? (64'd0 - acc_q) : acc_q;
  assign quot_fix = dz_q ? 32'hFFFF_FFFF
                         : (neg_lo_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0]);
  assign rem_fix  = neg_hi_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];

  // Next-state, datapath and HI/LO update
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    dz_d     = dz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!sig_clr) begin
          case (op_e)
            OP_MULT, OP_MULTU: begin
              state_d  = S_MUL;
              cnt_d    = 5'd31;
              acc_d    = {32'd0, mag_b};
              opnd_d   = mag_a;
              is_div_d = 1'b0;
              neg_lo_d = signed_op && (src_a_e[31] ^ src_b_e[31]);
              neg_hi_d = 1'b0;
              dz_d     = 1'b0;
            end
            OP_DIV, OP_DIVU: begin
              state_d  = S_DIV;
              cnt_d    = 5'd31;
              acc_d    = {32'd0, mag_a};
              opnd_d   = mag_b;
              is_div_d = 1'b1;
              // Division by zero keeps the quotient at all ones. The remainder
              // is the dividend magnitude, and negating it by the dividend
              // sign gives back the raw dividend.
              neg_lo_d = signed_op && (src_a_e[31] ^ src_b_e[31]) && !b_zero;
              neg_hi_d = signed_op && src_a_e[31];
              dz_d     = b_zero;
            end
            OP_MTHI: hi_d = src_a_e;
            OP_MTLO: lo_d = src_a_e;
            OP_NONE, OP_RSVD: ;
            default: ;
          endcase
        end
      end
      S_MUL: begin
        acc_d = {mul_sum, acc_q[31:1]};
        if (cnt_q == 5'd0) state_d = S_FIX;
        else               cnt_d   = cnt_q - 5'd1;
      end
      S_DIV: begin
        if (!div_trial[33]) acc_d = {div_trial[31:0], acc_q[30:0], 1'b1};
        else                acc_d = {acc_q[62:0], 1'b0};
        if (cnt_q == 5'd0) state_d = S_FIX;
        else               cnt_d   = cnt_q - 5'd1;
      end
      S_FIX: begin
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quot_fix;
        end else begin
          hi_d = prod_fix[63:32];
          lo_d = prod_fix[31:0];
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 5'd0;
      acc_q    <= 64'd0;
      opnd_q   <= 32'd0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      dz_q     <= dz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign hi        = hi_q;
  assign lo        = lo_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign stall_req = busy && (((op_e != OP_NONE) && (op_e != OP_RSVD)) || hilo_read_e);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_execute_muldiv.sv
// Bench for execute_muldiv: table of directed MULT/DIV vectors, random vectors
// checked against a behavioural model, and hand sequences for MTHI/MTLO,
// flushes, stalls during busy and asynchronous reset mid-operation.
module tb_execute_muldiv;

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  // Clock and reset
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  op_e;
  logic [31:0] src_a_e, src_b_e;
  logic        hilo_read_e, sig_clr;
  logic [31:0] hi, lo;
  logic        busy, stall_req, done;
  logic [1:0]  state_dbg;

  execute_muldiv dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .op_e        (op_e),
    .src_a_e     (src_a_e),
    .src_b_e     (src_b_e),
    .hilo_read_e (hilo_read_e),
    .sig_clr     (sig_clr),
    .hi          (hi),
    .lo          (lo),
    .busy        (busy),
    .stall_req   (stall_req),
    .done        (done),
    .state_dbg   (state_dbg)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t        vecs[$];
  logic [63:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] mhi = 32'd0;
  logic [31:0] mlo = 32'd0;

  // Scoreboard compare
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Behavioural reference: {hi, lo}
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint          sa, sb, sq, sr;
    longint unsigned ua, ub, uq, ur;
    logic [63:0]     res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    res = 64'd0;
    case (op)
      OP_MULT:  res = sa * sb;
      OP_MULTU: res = ua * ub;
      OP_DIV: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else begin
          sq = sa / sb;
          sr = sa % sb;
          res = {sr[31:0], sq[31:0]};
        end
      end
      OP_DIVU: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else begin
          uq = ua / ub;
          ur = ua % ub;
          res = {ur[31:0], uq[31:0]};
        end
      end
      default: res = {mhi, mlo};
    endcase
    return res;
  endfunction

  // Drive one multi-cycle op from the current (off-edge) time. inject selects
  // what to present while busy from cycle inj_at: 1 MFHI, 2 MTHI, 3 flush.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el,
                        input int inject, input int inj_at);
    int          n;
    logic [31:0] h0, l0, mthi_val;
    bit          stable, stall_ok, exp_stall;
    logic [63:0] exp;
    exp_q.push_back({eh, el});
    op_e = op; src_a_e = a; src_b_e = b; sig_clr = 1'b0; hilo_read_e = 1'b0;
    @(posedge clk); #1;
    op_e = OP_NONE; src_a_e = $urandom; src_b_e = $urandom;
    mthi_val = 32'hA5A5_0000 | $urandom_range(0, 16'hFFFF);
    h0 = hi; l0 = lo; stable = 1'b1; stall_ok = 1'b1; n = 0;
    check("busy_after_accept", {63'd0, busy}, 64'd1);
    while (busy && n < 40) begin
      if (n == inj_at) begin
        if (inject == 1) hilo_read_e = 1'b1;
        if (inject == 2) begin op_e = OP_MTHI; src_a_e = mthi_val; end
        if (inject == 3) begin op_e = OP_MULT; sig_clr = 1'b1; end
      end
      #1;
      exp_stall = (inject == 1 || inject == 2 || inject == 3) && (inj_at >= 0) && (n >= inj_at);
      if (stall_req !== exp_stall) stall_ok = 1'b0;
      if (hi !== h0 || lo !== l0 || done !== 1'b0) stable = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    check("latency", 64'(n), 64'd33);
    check("done_pulse", {63'd0, done}, 64'd1);
    check("busy_fall", {63'd0, busy}, 64'd0);
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got none, want one entry");
    end else begin
      exp = exp_q.pop_front();
      check("hilo_result", {hi, lo}, exp);
      mhi = exp[63:32]; mlo = exp[31:0];
    end
    check("hilo_stable_while_busy", {63'd0, stable}, 64'd1);
    check("stall_while_busy", {63'd0, stall_ok}, 64'd1);
    check("stall_after_busy", {63'd0, stall_req}, 64'd0);
    hilo_read_e = 1'b0;
    if (inject == 3) begin op_e = OP_NONE; sig_clr = 1'b0; end
    @(posedge clk); #1;
    check("done_single", {63'd0, done}, 64'd0);
    if (inject == 2) begin
      // The held MTHI is taken on the first edge after busy falls.
      check("mthi_replayed", {32'd0, hi}, {32'd0, mthi_val});
      mhi = mthi_val;
      op_e = OP_NONE;
    end
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    logic [63:0] rexp;

    op_e = OP_NONE; src_a_e = 32'd0; src_b_e = 32'd0;
    hilo_read_e = 1'b0; sig_clr = 1'b0;

    vecs.push_back('{OP_MULT,  32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA});
    vecs.push_back('{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001});
    vecs.push_back('{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
    vecs.push_back('{OP_DIVU,  32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF});
    vecs.push_back('{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000});
    vecs.push_back('{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF});
    vecs.push_back('{OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD});
    vecs.push_back('{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000});
    vecs.push_back('{OP_DIVU,  32'hFFFF_FFFF, 32'h0000_000A, 32'h0000_0005, 32'h1999_9999});
    vecs.push_back('{OP_MULT,  32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9});
    vecs.push_back('{OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000});

    // Reset state, with requests present that must not stall
    op_e = OP_MULT; hilo_read_e = 1'b1;
    #12;
    check("rst_hi", {32'd0, hi}, 64'd0);
    check("rst_lo", {32'd0, lo}, 64'd0);
    check("rst_busy_done_stall", {61'd0, busy, done, stall_req}, 64'd0);
    op_e = OP_NONE; hilo_read_e = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table; the first op is taken on the first edge after reset release
    for (int i = 0; i < vecs.size(); i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, 0, -1);

    // Random operands against the model
    for (int i = 0; i < 8; i++) begin
      rop = 3'($urandom_range(1, 4));
      ra  = $urandom;
      rb  = (i == 3) ? 32'd0 : $urandom;
      if (i == 5) rb = 32'($urandom_range(1, 15));
      rexp = model(rop, ra, rb);
      run_op(rop, ra, rb, rexp[63:32], rexp[31:0], 0, -1);
    end

    // MFHI arrives at cycle N+5 of a DIVU: stalls until the result lands
    rexp = model(OP_DIVU, 32'd100, 32'd7);
    run_op(OP_DIVU, 32'd100, 32'd7, rexp[63:32], rexp[31:0], 1, 4);
    // MTHI while busy is ignored, stalls, then replays
    rexp = model(OP_MULT, 32'hFFFF_0003, 32'h0000_1234);
    run_op(OP_MULT, 32'hFFFF_0003, 32'h0000_1234, rexp[63:32], rexp[31:0], 2, 3);
    // A flushed op while busy does not abort or restart the in-flight op
    rexp = model(OP_DIV, 32'h1234_5678, 32'hFFFF_FF00);
    run_op(OP_DIV, 32'h1234_5678, 32'hFFFF_FF00, rexp[63:32], rexp[31:0], 3, 7);

    // MTLO flushed, then taken
    op_e = OP_MTLO; src_a_e = 32'h1234_5678; sig_clr = 1'b1;
    @(posedge clk); #1;
    check("mtlo_flushed", {32'd0, lo}, {32'd0, mlo});
    sig_clr = 1'b0;
    @(posedge clk); #1;
    check("mtlo_written", {32'd0, lo}, 64'h0000_0000_1234_5678);
    check("mtlo_no_busy_done", {62'd0, busy, done}, 64'd0);
    mlo = 32'h1234_5678;
    op_e = OP_MTHI; src_a_e = 32'hCAFE_0001;
    @(posedge clk); #1;
    check("mthi_written", {hi, lo}, {32'hCAFE_0001, mlo});
    mhi = 32'hCAFE_0001;

    // Flushed MULT is discarded entirely
    op_e = OP_MULT; src_a_e = 32'd5; src_b_e = 32'd6; sig_clr = 1'b1;
    @(posedge clk); #1;
    check("mult_flushed", {62'd0, busy, done}, 64'd0);
    op_e = OP_NONE; sig_clr = 1'b0;

    // Asynchronous reset at cycle N+10 of a MULT
    op_e = OP_MULT; src_a_e = 32'h0000_1111; src_b_e = 32'h0000_2222;
    @(posedge clk); #1;
    op_e = OP_NONE;
    repeat (10) @(posedge clk);
    #2;
    hilo_read_e = 1'b1;
    rst_n = 1'b0;
    #1;
    check("midop_rst_hilo", {hi, lo}, 64'd0);
    check("midop_rst_busy_done_stall", {61'd0, busy, done, stall_req}, 64'd0);
    hilo_read_e = 1'b0;
    #3;
    rst_n = 1'b1;
    mhi = 32'd0; mlo = 32'd0;
    run_op(OP_MULTU, 32'd3, 32'd4, 32'd0, 32'h0000_000C, 0, -1);

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/execute_muldiv.md
EXECUTE_MULDIV -- requirements
Module: execute_muldiv

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on posedge clk.
REQ-002 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: op_e  input  3  E-stage HI/LO op: 0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as none).
REQ-004 SHALL have port: src_a_e  input  32  forwarded rs operand (multiplicand, dividend, MTHI/MTLO data).
REQ-005 SHALL have port: src_b_e  input  32  forwarded rt operand (multiplier, divisor).
REQ-006 SHALL have port: hilo_read_e  input  1  MFHI/MFLO present in E this cycle.
REQ-007 SHALL have port: sig_clr  input  1  E-stage flush for the current cycle's instruction.
REQ-008 SHALL have port: hi  output  32  architectural HI register.
REQ-009 SHALL have port: lo  output  32  architectural LO register.
REQ-010 SHALL have port: busy  output  1  high while state is not IDLE.
REQ-011 SHALL have port: stall_req  output  1  request to hazard unit to hold F/D/E.
REQ-012 SHALL have port: done  output  1  one-cycle pulse in the cycle after HI/LO take a MULT/DIV result.

Function
REQ-013 SHALL implement states IDLE, MUL, DIV, FIX; a 5-bit iteration counter; 64-bit working accumulator.
REQ-014 SHALL accept an op only in IDLE with sig_clr=0; with sig_clr=1 the op is discarded and no state changes.
REQ-015 SHALL, on accepting MTHI/MTLO, write src_a_e into hi/lo at that edge, remain IDLE, not pulse done.
REQ-016 SHALL, on accepting MULT/MULTU/DIV/DIVU, latch operand magnitudes (absolute value for signed ops, raw for unsigned) plus result-sign flags, load counter=31, enter MUL or DIV.
REQ-017 SHALL perform one shift-add (MUL) or one restoring subtract-shift (DIV) iteration per cycle; after the counter=0 iteration, enter FIX.
REQ-018 SHALL in FIX apply sign correction, write hi/lo at that edge, return to IDLE; done=1 for the following cycle.
REQ-019 SHALL give fixed latency: accept at edge N, hi/lo updated at edge N+33, busy high for the 33 cycles between, done high for cycle after N+33.
REQ-020 SHALL for MULT/MULTU write {hi,lo} = 64-bit product; MULT negates the product when operand signs differ.
REQ-021 SHALL for DIV/DIVU write lo = quotient, hi = remainder; DIV negates the quotient when signs differ, remainder takes the sign of the dividend.
REQ-022 SHALL for divisor 0 (DIV or DIVU) run full latency and write lo=0xFFFFFFFF, hi=src_a_e as latched.
REQ-023 SHALL for DIV 0x80000000 / 0xFFFFFFFF write lo=0x80000000, hi=0x00000000.
REQ-024 SHALL drive stall_req = busy AND (op_e != none OR hilo_read_e), combinationally.
REQ-025 SHALL ignore op_e while busy (no restart, no MTHI/MTLO write); the held instruction is re-presented after busy falls.
REQ-026 SHALL NOT abort an in-flight operation on sig_clr; only the newly presented op is affected.
REQ-027 SHALL keep hi/lo stable during MUL/DIV/FIX until the FIX edge.

Reset
REQ-028 SHALL on rst_n=0 immediately force state=IDLE, counter=0, accumulator=0, hi=0, lo=0, busy=0, done=0; stall_req thereby 0.
REQ-029 SHALL on reset asserted mid-operation discard the operation, leaving hi/lo=0 after release.
REQ-030 SHALL accept a new op on the first posedge after rst_n deasserts.

Verification
REQ-031 SHALL cover MULT 0xFFFFFFFE x 0x00000003 -> at edge N+33 hi=0xFFFFFFFF, lo=0xFFFFFFFA; done pulses once; busy high 33 cycles.
REQ-032 SHALL cover MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-033 SHALL cover DIV 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7/0 -> lo=0xFFFFFFFF, hi=0x00000007.
REQ-034 SHALL cover MFHI (hilo_read_e=1) presented at cycle N+5 of a DIVU -> stall_req=1 through cycle N+33, 0 after; hi unchanged until N+33.
REQ-035 SHALL cover MTLO 0x12345678 with sig_clr=1 -> lo unchanged; repeated with sig_clr=0 -> lo=0x12345678 next edge, busy stays 0.
REQ-036 SHALL cover rst_n pulsed low at cycle N+10 of a MULT -> hi=lo=0, busy=0 asynchronously; new MULTU 3x4 after release -> lo=0x0000000C.
